// File: rtl/cpu6_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu6_lsu_pkg
// Description : Shared sizes, FSM encoding and latched-request layout for the
//               cpu6 load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu6_lsu_pkg;

    localparam int c_xlen = 32;
    localparam int c_be_w = 4;

    localparam logic [1:0] c_size_b = 2'b00;
    localparam logic [1:0] c_size_h = 2'b01;
    localparam logic [1:0] c_size_w = 2'b10;

    localparam int c_state_size = 2;

    typedef enum logic [c_state_size-1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Request fields captured in IDLE; the bus side only ever sees this copy.
    typedef struct packed {
        logic              write;
        logic [1:0]        size;
        logic              uns;
        logic              misalign;
        logic [c_xlen-1:0] addr;
        logic [c_xlen-1:0] wdata;
    } req_t;

    // Size 2'b11 is illegal and behaves as a word access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            c_size_b: return 1'b0;
            c_size_h: return offset[0];
            c_size_w: return offset != 2'b00;
            default:  return offset != 2'b00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu6_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu6_lsu_if
// Description : Valid/grant/rvalid data-bus bundle between the LSU (master)
//               and data memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface cpu6_lsu_if
    import cpu6_lsu_pkg::*;
#(
    parameter int XLEN = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [XLEN-1:0]   bus_addr;
    logic [c_be_w-1:0] bus_be;
    logic [XLEN-1:0]   bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [XLEN-1:0]   bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/cpu6_dfflr.sv
`default_nettype none
// ============================================================================
// Module      : cpu6_dfflr
// Description : Load-enabled flop bank with synchronous active-high reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu6_dfflr #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu6_lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : cpu6_lsu_align
// Description : Byte-lane steering for stores, extract/extend for loads and
//               alignment check, all combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu6_lsu_align
    import cpu6_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic [1:0]        i_size,
    input  wire logic [1:0]        i_offset,
    input  wire logic              i_unsigned,
    input  wire logic [XLEN-1:0]   i_wdata,
    input  wire logic [XLEN-1:0]   i_rdata,
    output logic      [c_be_w-1:0] o_be,
    output logic      [XLEN-1:0]   o_wdata,
    output logic      [XLEN-1:0]   o_rdata,
    output logic                   o_misalign
);

    logic [XLEN-1:0] w_lane;

    // Bring the addressed byte/half down to bit 0 before extending.
    assign w_lane = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_rdata    = i_rdata;
        o_misalign = misaligned(i_size, i_offset);
        case (i_size)
            c_size_b: begin
                o_be    = 4'b0001 << i_offset;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{~i_unsigned & w_lane[7]}}, w_lane[7:0]};
            end
            c_size_h: begin
                o_be    = 4'b0011 << i_offset;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = {{16{~i_unsigned & w_lane[15]}}, w_lane[15:0]};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu6_lsu.sv
`default_nettype none
// ============================================================================
// Module      : cpu6_lsu
// Description : Load/store unit running E-stage memory requests over a
//               multi-cycle valid/grant/rvalid bus, stalling the core meanwhile.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu6_lsu
    import cpu6_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            req_valid,
    input  wire logic            req_write,
    input  wire logic [1:0]      req_size,
    input  wire logic            req_unsigned,
    input  wire logic [XLEN-1:0] req_addr,
    input  wire logic [XLEN-1:0] req_wdata,
    output logic                 stall,
    output logic                 resp_valid,
    output logic      [XLEN-1:0] resp_rdata,
    output logic                 resp_misalign,
    cpu6_lsu_if.master           bus
);

    if (XLEN != 32) begin : g_xlen_check
        $error("cpu6_lsu: XLEN must be 32");
    end

    logic [c_state_size-1:0] r_state_q;
    state_t                  w_state;
    state_t                  w_state_nxt;
    req_t                    r_req;
    req_t                    w_req_d;
    logic                    w_idle;
    logic                    w_accept;
    logic                    w_bus_req;

    logic [1:0]        w_al_size;
    logic [1:0]        w_al_offset;
    logic              w_al_unsigned;
    logic [XLEN-1:0]   w_al_wdata;
    logic [c_be_w-1:0] w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN-1:0]   w_rdata_ext;
    logic              w_misalign;

    logic              w_resp_en;
    logic [XLEN-1:0]   w_resp_d;

    cpu6_dfflr #(.WIDTH(c_state_size)) u_state (
        .clk  (clk),
        .rst  (reset),
        .i_en (1'b1),
        .i_d  (w_state_nxt),
        .o_q  (r_state_q)
    );

    assign w_state  = state_t'(r_state_q);
    assign w_idle   = (w_state == ST_IDLE);
    assign w_accept = w_idle && req_valid;

    // In IDLE the aligner looks at the live request (for the misalign
    // decision); afterwards it only ever sees the latched copy.
    assign w_al_size     = w_idle ? req_size       : r_req.size;
    assign w_al_offset   = w_idle ? req_addr[1:0]  : r_req.addr[1:0];
    assign w_al_unsigned = w_idle ? req_unsigned   : r_req.uns;
    assign w_al_wdata    = w_idle ? req_wdata      : r_req.wdata;

    cpu6_lsu_align #(.XLEN(XLEN)) u_align (
        .i_size     (w_al_size),
        .i_offset   (w_al_offset),
        .i_unsigned (w_al_unsigned),
        .i_wdata    (w_al_wdata),
        .i_rdata    (bus.bus_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata_ext),
        .o_misalign (w_misalign)
    );

    always_comb begin
        w_req_d          = '0;
        w_req_d.write    = req_write;
        w_req_d.size     = req_size;
        w_req_d.uns      = req_unsigned;
        w_req_d.misalign = w_misalign;
        w_req_d.addr     = req_addr;
        w_req_d.wdata    = req_wdata;
    end

    cpu6_dfflr #(.WIDTH($bits(req_t))) u_req (
        .clk  (clk),
        .rst  (reset),
        .i_en (w_accept),
        .i_d  (w_req_d),
        .o_q  (r_req)
    );

    // Load data is captured on rvalid; stores and rejected accesses report 0.
    assign w_resp_en = ((w_state == ST_WAIT) && bus.bus_rvalid) || (w_accept && w_misalign);
    assign w_resp_d  = ((w_state == ST_WAIT) && !r_req.write) ? w_rdata_ext : '0;

    cpu6_dfflr #(.WIDTH(XLEN)) u_resp (
        .clk  (clk),
        .rst  (reset),
        .i_en (w_resp_en),
        .i_d  (w_resp_d),
        .o_q  (resp_rdata)
    );

    always_comb begin
        w_state_nxt = w_state;
        stall       = 1'b0;
        w_bus_req   = 1'b0;
        case (w_state)
            ST_IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    w_state_nxt = w_misalign ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                stall     = 1'b1;
                w_bus_req = 1'b1;
                if (bus.bus_gnt) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (bus.bus_rvalid) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign resp_valid    = (w_state == ST_DONE);
    assign resp_misalign = r_req.misalign;

    assign bus.bus_req   = w_bus_req;
    assign bus.bus_we    = r_req.write;
    assign bus.bus_addr  = {r_req.addr[XLEN-1:2], 2'b00};
    assign bus.bus_be    = w_be;
    assign bus.bus_wdata = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_cpu6_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu6_lsu
// Description : Randomised scoreboard bench for cpu6_lsu with a memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu6_lsu;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misalign;

    cpu6_lsu_if #(.XLEN(32)) bif ();

    cpu6_lsu #(.XLEN(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .stall         (stall),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign),
        .bus           (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          g;
        int          r;
        bit          spur;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          stall_cyc;
    } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];
    int    n_checks  = 0;
    int    n_fail    = 0;
    int    done_cnt  = 0;
    int    stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    endtask

    // Reference: byte-lane view of memory accesses.
    function automatic void model(input bit w, input bit [1:0] sz, input bit uns,
                                  input bit [31:0] a, input bit [31:0] wd, input bit [31:0] rd,
                                  output bit mis, output bit [3:0] be,
                                  output bit [31:0] bwd, output bit [31:0] res);
        int nb;
        int off;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a % 4);
        mis = (a % nb) != 0;
        be  = '0;
        bwd = '0;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + nb) be[i] = 1'b1;
            bwd[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        if (!w && !mis) begin
            for (int k = 0; k < nb; k++) res[8*k +: 8] = rd[8*(off+k) +: 8];
            if (!uns && nb < 4 && res[8*nb-1]) begin
                for (int k = nb; k < 4; k++) res[8*k +: 8] = 8'hFF;
            end
        end
    endfunction

    task automatic check_bus(input bus_t t);
        check("bus_req", bif.bus_req, 1'b1);
        check("bus_we", bif.bus_we, t.we);
        check("bus_addr", bif.bus_addr, t.addr);
        check("bus_be", bif.bus_be, t.be);
        if (t.we) check("bus_wdata", bif.bus_wdata, t.wdata);
    endtask

    // Issued at posedge+1; returns at posedge+1 with the DUT back in IDLE.
    task automatic do_txn(input bit w, input bit [1:0] sz, input bit uns, input bit [31:0] a,
                          input bit [31:0] wd, input bit [31:0] rd, input int g, input int r,
                          input bit spur);
        bit        mis;
        bit [3:0]  be;
        bit [31:0] bwd;
        bit [31:0] res;
        bus_t      bt;
        resp_t     rt;
        int        start;
        int        k;
        model(w, sz, uns, a, wd, rd, mis, be, bwd, res);
        if (!mis) begin
            bt.we = w; bt.addr = {a[31:2], 2'b00}; bt.be = be; bt.wdata = bwd;
            bt.rdata = rd; bt.g = g; bt.r = r; bt.spur = spur;
            bus_q.push_back(bt);
        end
        rt.rdata = res; rt.mis = mis; rt.stall_cyc = mis ? 1 : g + r + 3;
        resp_q.push_back(rt);
        start = done_cnt;
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        // After acceptance only the latched copy may matter.
        req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        k = 0;
        while (done_cnt == start && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (done_cnt == start) begin
            check("txn_timeout", done_cnt - start, 1);
            finish_run();
        end
        req_valid = 1'b0;
    endtask

    // Response monitor.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_cnt = 0;
            end else if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", resp_valid, 1'b0);
                end else begin
                    e = resp_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_misalign", resp_misalign, e.mis);
                    check("stall_cycles", stall_cnt, e.stall_cyc);
                    check("stall_in_done", stall, 1'b0);
                end
                stall_cnt = 0;
                done_cnt++;
            end else if (stall) begin
                stall_cnt++;
            end
        end
    end

    // Memory responder.
    initial begin
        bus_t t;
        bif.bus_gnt = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (bif.bus_req === 1'b1) begin
                if (bus_q.size() == 0) begin
                    check("bus_req_unexpected", bif.bus_req, 1'b0);
                end else begin
                    t = bus_q.pop_front();
                    for (int i = 0; i < t.g; i++) begin
                        check_bus(t);
                        bif.bus_gnt = 1'b0; bif.bus_rvalid = t.spur; bif.bus_rdata = $urandom;
                        @(negedge clk);
                    end
                    check_bus(t);
                    bif.bus_gnt = 1'b1; bif.bus_rvalid = 1'b0;
                    @(negedge clk);
                    bif.bus_gnt = 1'b0;
                    for (int i = 0; i < t.r; i++) begin
                        check("bus_req_after_gnt", bif.bus_req, 1'b0);
                        @(negedge clk);
                    end
                    check("bus_req_after_gnt", bif.bus_req, 1'b0);
                    bif.bus_rvalid = 1'b1; bif.bus_rdata = t.rdata;
                    @(negedge clk);
                    bif.bus_rvalid = 1'b0; bif.bus_rdata = $urandom;
                end
            end else begin
                // Stray rvalid while idle must be ignored.
                bif.bus_rvalid = !resp_valid && ($urandom_range(0, 7) == 0);
                bif.bus_rdata  = $urandom;
            end
        end
    end

    initial begin
        bit        w;
        bit        uns;
        bit [1:0]  sz;
        bit [31:0] a;
        int        nb;
        int        gap;
        bit        mis;
        bit [3:0]  be;
        bit [31:0] bwd;
        bit [31:0] res;
        bus_t      bt;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_misalign", resp_misalign, 1'b0);
        check("rst_bus_req", bif.bus_req, 1'b0);
        check("rst_stall", stall, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        do_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
        do_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FF0000, 0, 1, 1'b0);
        do_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FF0000, 1, 0, 1'b0);
        do_txn(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234ABCD, 32'h5A5A5A5A, 0, 0, 1'b0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h11111111, 0, 0, 1'b0);
        do_txn(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 32'h22222222, 0, 0, 1'b0);
        do_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D, 4, 2, 1'b1);
        do_txn(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h8001FFFF, 0, 0, 1'b0);

        // Reset while waiting for rvalid; the late rvalid must be ignored.
        model(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h12345678, mis, be, bwd, res);
        bt.we = 1'b0; bt.addr = 32'h200; bt.be = be; bt.wdata = bwd;
        bt.rdata = 32'h12345678; bt.g = 0; bt.r = 4; bt.spur = 1'b0;
        bus_q.push_back(bt);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h200; req_wdata = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rstwait_resp_valid", resp_valid, 1'b0);
            check("rstwait_stall", stall, 1'b0);
            check("rstwait_bus_req", bif.bus_req, 1'b0);
        end
        check("rstwait_resp_rdata", resp_rdata, 32'h0);
        @(posedge clk); #1;
        do_txn(1'b0, 2'd2, 1'b0, 32'h204, 32'h0, 32'h0BADF00D, 0, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            w   = 1'($urandom);
            uns = 1'($urandom);
            sz  = 2'($urandom);
            a   = $urandom;
            nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(nb) - 32'd1);
            gap = $urandom_range(0, 2);
            for (int i = 0; i < gap; i++) begin
                req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
                @(posedge clk); #1;
            end
            do_txn(w, sz, uns, a, $urandom, $urandom, $urandom_range(0, 3),
                   $urandom_range(0, 3), 1'($urandom));
        end

        repeat (5) @(posedge clk);
        check("resp_queue_left", resp_q.size(), 0);
        check("bus_queue_left", bus_q.size(), 0);
        finish_run();
    end

endmodule
`default_nettype wire

// File: doc/cpu6_lsu.md
Name: cpu6_lsu

Overview:
- Load/store unit directly downstream of the core's execute stage.
- Consumes the E-stage memory request (address, store data, access size, write flag) and runs it on a multi-cycle valid/grant/rvalid data bus.
- Returns sign- or zero-extended load data and holds `stall` high until the access completes.
- Replaces the core's single-cycle `dataaddr`/`writedata`/`readdata` port, so the data memory may take several cycles.

Parameters:
- XLEN, 32, data and address width; must be 32 (byte-enable width fixed at 4).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  E-stage holds a load or store this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is illegal and treated as word
- req_unsigned  in  1  zero-extend load result (lbu/lhu)
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-aligned
- stall  out  1  freeze fetch and E stage
- resp_valid  out  1  access complete this cycle
- resp_rdata  out  XLEN  extended load data
- resp_misalign  out  1  access was rejected as misaligned
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  XLEN  word-aligned address: {addr[31:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  XLEN  lane-replicated store data
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  read data valid, or write acknowledge
- bus_rdata  in  XLEN  read data, full word

Behaviour:
- The FSM has four states: IDLE, REQ, WAIT and DONE. Reset forces IDLE.
- Reset values of registered outputs and latches: `resp_*` = 0, `bus_req` = 0, all latched request fields = 0.
- IDLE:
  - If `req_valid` is high, latch `req_*`.
  - Go to DONE if misaligned, else to REQ.
  - `stall` = `req_valid`.
- Misaligned means: half with addr[0]=1, or word with addr[1:0]≠0.
- REQ:
  - `bus_req`=1 and `bus_*` are driven from the latched fields.
  - If `bus_gnt`, go to WAIT.
  - `stall`=1.
- WAIT:
  - `bus_req`=0.
  - On `bus_rvalid`, capture the extended data into `resp_rdata` (0 for stores) and go to DONE.
  - `stall`=1.
- DONE:
  - `resp_valid`=1 and `stall`=0; the core advances this cycle.
  - Always go to IDLE next cycle; a new `req_valid` is sampled only in IDLE.
- Minimum latency, with same-cycle gnt and rvalid: request seen in cycle 0, result in cycle 3, `stall` high for cycles 0–2.
- Misaligned access:
  - No bus activity.
  - DONE with `resp_misalign`=1 and `resp_rdata`=0; `stall` high for 1 cycle.
- `bus_rvalid` in IDLE or REQ is ignored. `bus_gnt` outside REQ is ignored.
- `bus_req` drops only after `gnt`; the latched `bus_*` fields stay stable while `bus_req` is high.
- Store lanes:
  - Byte: `bus_wdata` = {4{wdata[7:0]}}, `bus_be` = 4'b0001 << addr[1:0].
  - Half: `bus_wdata` = {2{wdata[15:0]}}, `bus_be` = 4'b0011 << addr[1:0].
  - Word: `bus_wdata` = `req_wdata`, `bus_be` = 4'b1111.
- Load `bus_be` follows the same size/offset rule.
- Load extract:
  - Byte = rdata >> (8·addr[1:0]), low 8 bits; half = rdata >> (8·addr[1:0]), low 16 bits.
  - Sign-extend unless `req_unsigned`.
- `resp_rdata` holds its value until the next DONE.
- Reset mid-operation (REQ or WAIT): return to IDLE, drop `bus_req`; a late `bus_rvalid` is ignored. The bus must tolerate an abandoned request.
- The core must hold `req_*` stable while `stall`=1; the LSU uses only the latched copy after IDLE.

Decomposition:
- Shared defines go in `defines.v`:
  - `CPU6_LSU_SIZE_B`/`_H`/`_W`
  - `CPU6_LSU_STATE_SIZE` and the four state encodings
- One combinational sub-module, `cpu6_lsu_align`. It takes size, offset, unsigned, wdata and rdata, and produces `be`, lane-replicated wdata, extended rdata and misalign.
- The FSM and latches use `cpu6_dfflr`.

Test Plan:
- Word load: addr=0x100, gnt immediate, rvalid next cycle with rdata=0xDEADBEEF.
  - `bus_addr`=0x100, `be`=4'b1111.
  - `resp_rdata`=0xDEADBEEF in cycle 3; `stall` high exactly cycles 0–2.
- Byte loads: addr=0x103, rdata=0x80FF0000.
  - Signed: `resp_rdata`=0xFFFFFF80. Unsigned: 0x00000080. `be`=4'b1000.
- Half store: addr=0x22, wdata=0x1234ABCD.
  - `bus_wdata`=0xABCDABCD, `be`=4'b1100, `bus_we`=1.
  - Completes on rvalid with `resp_rdata`=0.
- Misaligned: word load at 0x101 and half load at 0x3.
  - `bus_req` never asserts, `resp_misalign`=1, `stall` high 1 cycle.
- Backpressure: `gnt` low for 4 cycles, then rvalid 3 cycles after gnt.
  - `bus_*` stable during REQ; `stall` high for 1+5+3 cycles.
  - A spurious rvalid during REQ is ignored.
- Reset in WAIT: assert reset, then deliver rvalid.
  - FSM is in IDLE and `resp_valid`=0.
  - The next request proceeds normally.
